// File: rtl/rc4_prga_decrypt_fsm.sv
// RC4 keystream generator and decryptor.
// Takes over the S memory once init and KSA are complete. For each message byte it
// performs the PRGA swap, fetches the keystream byte, XORs it with the encrypted ROM
// and writes the plaintext byte into the decrypted-message RAM. Ten cycles per byte.
module rc4_prga_decrypt_fsm #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_q,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        enc_q,
    output logic [MSG_AW-1:0] enc_addr,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] INC_I  = 4'd1;
    localparam logic [3:0] RD_SI  = 4'd2;
    localparam logic [3:0] GET_SI = 4'd3;
    localparam logic [3:0] RD_SJ  = 4'd4;
    localparam logic [3:0] GET_SJ = 4'd5;
    localparam logic [3:0] WR_SI  = 4'd6;
    localparam logic [3:0] WR_SJ  = 4'd7;
    localparam logic [3:0] RD_F   = 4'd8;
    localparam logic [3:0] GET_F  = 4'd9;
    localparam logic [3:0] WR_DEC = 4'd10;
    localparam logic [3:0] DONE   = 4'd11;

    // Index of the last message byte; k wraps naturally when MSG_LEN == 2**MSG_AW.
    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    logic [3:0]        state;
    logic [7:0]        i;
    logic [7:0]        j;
    logic [7:0]        si;
    logic [7:0]        sj;
    logic [MSG_AW-1:0] k;

    // Sequencer and datapath registers; reset has priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            i        <= 8'd0;
            j        <= 8'd0;
            k        <= '0;
            si       <= 8'd0;
            sj       <= 8'd0;
            dec_data <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A (re)start always begins a fresh PRGA pass over the current S contents.
                    if (start) begin
                        i     <= 8'd0;
                        j     <= 8'd0;
                        k     <= '0;
                        state <= INC_I;
                    end
                end
                INC_I: begin
                    i     <= i + 8'd1;
                    state <= RD_SI;
                end
                RD_SI:  state <= GET_SI;
                GET_SI: begin
                    si    <= s_q;
                    j     <= j + s_q;
                    state <= RD_SJ;
                end
                RD_SJ:  state <= GET_SJ;
                GET_SJ: begin
                    sj    <= s_q;
                    state <= WR_SI;
                end
                WR_SI:  state <= WR_SJ;
                WR_SJ:  state <= RD_F;
                RD_F:   state <= GET_F;
                GET_F: begin
                    dec_data <= s_q ^ enc_q;
                    state    <= WR_DEC;
                end
                WR_DEC: begin
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        k     <= k + MSG_AW'(1);
                        state <= INC_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side strobes decoded from state; everything idles at zero by default.
    // When i == j the second write (si to j) lands last, leaving S unchanged as RC4 requires.
    always_comb begin
        s_addr   = 8'd0;
        s_data   = 8'd0;
        s_wren   = 1'b0;
        enc_addr = '0;
        dec_addr = '0;
        dec_wren = 1'b0;
        case (state)
            RD_SI: s_addr = i;
            RD_SJ: s_addr = j;
            WR_SI: begin
                s_addr = i;
                s_data = sj;
                s_wren = 1'b1;
            end
            WR_SJ: begin
                s_addr = j;
                s_data = si;
                s_wren = 1'b1;
            end
            RD_F: begin
                s_addr   = si + sj;
                enc_addr = k;
            end
            WR_DEC: begin
                dec_addr = k;
                dec_wren = 1'b1;
            end
            default: ;
        endcase
    end

    // Status flags.
    always_comb begin
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

endmodule
